// File: rtl/aes_key_expander_pkg.sv
// Shared AES definitions for the key schedule: word type, FSM states,
// key-size helpers, GF(2^8) doubling and the forward S-box table.
package aes_key_expander_pkg;

  typedef logic [31:0] word_t;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_GEN  = 2'd1,
    ST_HOLD = 2'd2
  } state_e;

  function automatic int aes_nk(input int key_bits);
    return key_bits / 32;
  endfunction

  function automatic int aes_nr(input int key_bits);
    return (key_bits / 32) + 6;
  endfunction

  function automatic logic [7:0] xtime(input logic [7:0] b);
    return {b[6:0], 1'b0} ^ (b[7] ? 8'h1b : 8'h00);
  endfunction

  localparam logic [7:0] SBOX [256] = '{
    8'h63, 8'h7c, 8'h77, 8'h7b, 8'hf2, 8'h6b, 8'h6f, 8'hc5, 8'h30, 8'h01, 8'h67, 8'h2b, 8'hfe, 8'hd7, 8'hab, 8'h76,
    8'hca, 8'h82, 8'hc9, 8'h7d, 8'hfa, 8'h59, 8'h47, 8'hf0, 8'had, 8'hd4, 8'ha2, 8'haf, 8'h9c, 8'ha4, 8'h72, 8'hc0,
    8'hb7, 8'hfd, 8'h93, 8'h26, 8'h36, 8'h3f, 8'hf7, 8'hcc, 8'h34, 8'ha5, 8'he5, 8'hf1, 8'h71, 8'hd8, 8'h31, 8'h15,
    8'h04, 8'hc7, 8'h23, 8'hc3, 8'h18, 8'h96, 8'h05, 8'h9a, 8'h07, 8'h12, 8'h80, 8'he2, 8'heb, 8'h27, 8'hb2, 8'h75,
    8'h09, 8'h83, 8'h2c, 8'h1a, 8'h1b, 8'h6e, 8'h5a, 8'ha0, 8'h52, 8'h3b, 8'hd6, 8'hb3, 8'h29, 8'he3, 8'h2f, 8'h84,
    8'h53, 8'hd1, 8'h00, 8'hed, 8'h20, 8'hfc, 8'hb1, 8'h5b, 8'h6a, 8'hcb, 8'hbe, 8'h39, 8'h4a, 8'h4c, 8'h58, 8'hcf,
    8'hd0, 8'hef, 8'haa, 8'hfb, 8'h43, 8'h4d, 8'h33, 8'h85, 8'h45, 8'hf9, 8'h02, 8'h7f, 8'h50, 8'h3c, 8'h9f, 8'ha8,
    8'h51, 8'ha3, 8'h40, 8'h8f, 8'h92, 8'h9d, 8'h38, 8'hf5, 8'hbc, 8'hb6, 8'hda, 8'h21, 8'h10, 8'hff, 8'hf3, 8'hd2,
    8'hcd, 8'h0c, 8'h13, 8'hec, 8'h5f, 8'h97, 8'h44, 8'h17, 8'hc4, 8'ha7, 8'h7e, 8'h3d, 8'h64, 8'h5d, 8'h19, 8'h73,
    8'h60, 8'h81, 8'h4f, 8'hdc, 8'h22, 8'h2a, 8'h90, 8'h88, 8'h46, 8'hee, 8'hb8, 8'h14, 8'hde, 8'h5e, 8'h0b, 8'hdb,
    8'he0, 8'h32, 8'h3a, 8'h0a, 8'h49, 8'h06, 8'h24, 8'h5c, 8'hc2, 8'hd3, 8'hac, 8'h62, 8'h91, 8'h95, 8'he4, 8'h79,
    8'he7, 8'hc8, 8'h37, 8'h6d, 8'h8d, 8'hd5, 8'h4e, 8'ha9, 8'h6c, 8'h56, 8'hf4, 8'hea, 8'h65, 8'h7a, 8'hae, 8'h08,
    8'hba, 8'h78, 8'h25, 8'h2e, 8'h1c, 8'ha6, 8'hb4, 8'hc6, 8'he8, 8'hdd, 8'h74, 8'h1f, 8'h4b, 8'hbd, 8'h8b, 8'h8a,
    8'h70, 8'h3e, 8'hb5, 8'h66, 8'h48, 8'h03, 8'hf6, 8'h0e, 8'h61, 8'h35, 8'h57, 8'hb9, 8'h86, 8'hc1, 8'h1d, 8'h9e,
    8'he1, 8'hf8, 8'h98, 8'h11, 8'h69, 8'hd9, 8'h8e, 8'h94, 8'h9b, 8'h1e, 8'h87, 8'he9, 8'hce, 8'h55, 8'h28, 8'hdf,
    8'h8c, 8'ha1, 8'h89, 8'h0d, 8'hbf, 8'he6, 8'h42, 8'h68, 8'h41, 8'h99, 8'h2d, 8'h0f, 8'hb0, 8'h54, 8'hbb, 8'h16
  };

endpackage

// File: rtl/aes_key_expander_sbox.sv
// Single-byte combinational AES forward S-box lookup; four of these form SubWord.
module aes_key_expander_sbox
  import aes_key_expander_pkg::*;
(
  input  logic [7:0] in_byte,
  output logic [7:0] out_byte
);

  assign out_byte = SBOX[in_byte];

endmodule

// File: rtl/aes_key_expander.sv
// Word-serial AES key schedule: generates one schedule word per cycle and
// presents each group of four words as a round key behind a valid/ready handshake.
module aes_key_expander
  import aes_key_expander_pkg::*;
#(
  parameter int KEY_BITS = 128
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                key_valid,
  output logic                key_ready,
  input  logic [KEY_BITS-1:0] key,
  input  logic                abort,
  output logic                rk_valid,
  input  logic                rk_ready,
  output logic [127:0]        rk_data,
  output logic [3:0]          rk_idx,
  output logic                rk_last,
  output logic                busy
);

  localparam int NK = aes_nk(KEY_BITS);
  localparam int NR = aes_nr(KEY_BITS);
  localparam logic [2:0] NK_LAST = 3'(NK - 1);
  localparam logic [3:0] NR_IDX  = 4'(NR);
  localparam logic [5:0] NK_W    = 6'(NK);

  if (KEY_BITS != 128 && KEY_BITS != 192 && KEY_BITS != 256) begin : g_bad_key_bits
    $error("aes_key_expander: KEY_BITS must be 128, 192 or 256");
  end

  state_e     state_q, state_d;
  word_t      win_q [NK];
  word_t      win_d [NK];
  word_t      col_q [3];
  word_t      col_d [3];
  logic [1:0] col_cnt_q, col_cnt_d;
  logic [5:0] i_q, i_d;
  logic [2:0] mod_q, mod_d;
  logic [7:0] rcon_q, rcon_d;
  logic [127:0] rk_data_q, rk_data_d;
  logic [3:0] rk_idx_q, rk_idx_d;
  logic       rk_last_q, rk_last_d;

  word_t prev_w, sub_in, sub_out, t_w, new_w;
  logic  i_ge_nk;

  // The window is rotated through itself while i < NK, so the oldest slot always feeds w[i].
  assign prev_w  = win_q[NK-1];
  assign i_ge_nk = (i_q >= NK_W);
  assign sub_in  = (mod_q == 3'd0) ? {prev_w[23:0], prev_w[31:24]} : prev_w;

  for (genvar b = 0; b < 4; b++) begin : g_subword
    aes_key_expander_sbox u_sbox (
      .in_byte  (sub_in[8*b +: 8]),
      .out_byte (sub_out[8*b +: 8])
    );
  end

  always_comb begin
    t_w = prev_w;
    if (mod_q == 3'd0) begin
      t_w = sub_out ^ {rcon_q, 24'h000000};
    end else if ((NK == 8) && (mod_q == 3'd4)) begin
      t_w = sub_out;
    end else begin
      t_w = prev_w;
    end
    new_w = win_q[0] ^ (i_ge_nk ? t_w : 32'h00000000);
  end

  always_comb begin
    state_d   = state_q;
    win_d     = win_q;
    col_d     = col_q;
    col_cnt_d = col_cnt_q;
    i_d       = i_q;
    mod_d     = mod_q;
    rcon_d    = rcon_q;
    rk_data_d = rk_data_q;
    rk_idx_d  = rk_idx_q;
    rk_last_d = rk_last_q;

    case (state_q)
      ST_IDLE: begin
        if (key_valid) begin
          state_d = ST_GEN;
          for (int j = 0; j < NK; j++) begin
            win_d[j] = key[KEY_BITS-1-32*j -: 32];
          end
          i_d       = 6'd0;
          mod_d     = 3'd0;
          col_cnt_d = 2'd0;
          rcon_d    = 8'h01;
          rk_idx_d  = 4'd0;
          rk_last_d = 1'b0;
        end else begin
          state_d = ST_IDLE;
        end
      end
      ST_GEN: begin
        for (int j = 0; j < NK - 1; j++) begin
          win_d[j] = win_q[j+1];
        end
        win_d[NK-1] = new_w;
        i_d   = i_q + 6'd1;
        mod_d = (mod_q == NK_LAST) ? 3'd0 : mod_q + 3'd1;
        if (i_ge_nk && (mod_q == 3'd0)) begin
          rcon_d = xtime(rcon_q);
        end else begin
          rcon_d = rcon_q;
        end
        if (col_cnt_q == 2'd3) begin
          rk_data_d = {col_q[0], col_q[1], col_q[2], new_w};
          rk_last_d = (rk_idx_q == NR_IDX);
          col_cnt_d = 2'd0;
          state_d   = ST_HOLD;
        end else begin
          col_d[col_cnt_q] = new_w;
          col_cnt_d        = col_cnt_q + 2'd1;
        end
      end
      ST_HOLD: begin
        if (rk_ready && rk_last_q) begin
          state_d   = ST_IDLE;
          rk_last_d = 1'b0;
        end else if (rk_ready) begin
          state_d  = ST_GEN;
          rk_idx_d = rk_idx_q + 4'd1;
        end else begin
          state_d = ST_HOLD;
        end
      end
      default: begin
        state_d = ST_IDLE;
      end
    endcase

    // Abort overrides any handshake or key accept in the same cycle.
    if (abort) begin
      state_d   = ST_IDLE;
      col_cnt_d = 2'd0;
      i_d       = 6'd0;
      mod_d     = 3'd0;
      rcon_d    = 8'h01;
      rk_data_d = 128'h0;
      rk_idx_d  = 4'd0;
      rk_last_d = 1'b0;
    end else begin
      rcon_d = rcon_d;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q   <= ST_IDLE;
      for (int j = 0; j < NK; j++) begin
        win_q[j] <= 32'h00000000;
      end
      for (int j = 0; j < 3; j++) begin
        col_q[j] <= 32'h00000000;
      end
      col_cnt_q <= 2'd0;
      i_q       <= 6'd0;
      mod_q     <= 3'd0;
      rcon_q    <= 8'h01;
      rk_data_q <= 128'h0;
      rk_idx_q  <= 4'd0;
      rk_last_q <= 1'b0;
    end else begin
      state_q   <= state_d;
      win_q     <= win_d;
      col_q     <= col_d;
      col_cnt_q <= col_cnt_d;
      i_q       <= i_d;
      mod_q     <= mod_d;
      rcon_q    <= rcon_d;
      rk_data_q <= rk_data_d;
      rk_idx_q  <= rk_idx_d;
      rk_last_q <= rk_last_d;
    end
  end

  assign key_ready = (state_q == ST_IDLE);
  assign busy      = (state_q != ST_IDLE);
  assign rk_valid  = (state_q == ST_HOLD);
  assign rk_data   = rk_data_q;
  assign rk_idx    = rk_idx_q;
  assign rk_last   = rk_last_q;

endmodule

// File: tb/tb_aes_key_expander.sv
// Bench for aes_key_expander: three instances (128/192/256) checked every cycle
// against a FIPS-197 style reference schedule and a handshake-level model.
module tb_aes_key_expander;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic         rst, abort, rk_ready;
  logic [2:0]   key_valid, key_ready, rk_valid, rk_last, busy;
  logic [127:0] key0;
  logic [191:0] key1;
  logic [255:0] key2;
  logic [127:0] rk_data [3];
  logic [3:0]   rk_idx [3];

  aes_key_expander #(.KEY_BITS(128)) u_dut128 (
    .clk(clk), .rst(rst), .key_valid(key_valid[0]), .key_ready(key_ready[0]), .key(key0),
    .abort(abort), .rk_valid(rk_valid[0]), .rk_ready(rk_ready), .rk_data(rk_data[0]),
    .rk_idx(rk_idx[0]), .rk_last(rk_last[0]), .busy(busy[0]));
  aes_key_expander #(.KEY_BITS(192)) u_dut192 (
    .clk(clk), .rst(rst), .key_valid(key_valid[1]), .key_ready(key_ready[1]), .key(key1),
    .abort(abort), .rk_valid(rk_valid[1]), .rk_ready(rk_ready), .rk_data(rk_data[1]),
    .rk_idx(rk_idx[1]), .rk_last(rk_last[1]), .busy(busy[1]));
  aes_key_expander #(.KEY_BITS(256)) u_dut256 (
    .clk(clk), .rst(rst), .key_valid(key_valid[2]), .key_ready(key_ready[2]), .key(key2),
    .abort(abort), .rk_valid(rk_valid[2]), .rk_ready(rk_ready), .rk_data(rk_data[2]),
    .rk_idx(rk_idx[2]), .rk_last(rk_last[2]), .busy(busy[2]));

  int checks = 0;
  int failures = 0;
  int cyc = 0;
  bit run_chk = 1'b0;

  logic [7:0]   sb [256];
  logic [127:0] exp_rk [3][15];
  int mode [3];
  int gcnt [3];
  int kidx [3];
  int done [3];
  int accept_cyc [3];
  int last_cyc [3];
  int nr_of [3] = '{10, 12, 14};

  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string nm, input logic [127:0] act, input logic [127:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%h required=%h", nm, act, exp);
    end
  endtask

  function automatic logic [7:0] gmul(input logic [7:0] a, input logic [7:0] b);
    logic [7:0] p, x;
    p = 8'h00;
    x = a;
    for (int n = 0; n < 8; n++) begin
      if (b[n]) p ^= x;
      x = {x[6:0], 1'b0} ^ (x[7] ? 8'h1b : 8'h00);
    end
    return p;
  endfunction

  function automatic logic [7:0] rotl(input logic [7:0] v, input int n);
    return 8'((v << n) | (v >> (8 - n)));
  endfunction

  // Reference S-box from its definition: multiplicative inverse then affine map.
  task automatic build_sbox();
    for (int b = 0; b < 256; b++) begin
      logic [7:0] inv, bb;
      bb = 8'(b);
      inv = 8'h00;
      if (b != 0) begin
        for (int x = 1; x < 256; x++) if (gmul(bb, 8'(x)) == 8'h01) inv = 8'(x);
      end
      sb[b] = inv ^ rotl(inv, 1) ^ rotl(inv, 2) ^ rotl(inv, 3) ^ rotl(inv, 4) ^ 8'h63;
    end
  endtask

  function automatic logic [31:0] subw(input logic [31:0] t);
    return {sb[t[31:24]], sb[t[23:16]], sb[t[15:8]], sb[t[7:0]]};
  endfunction

  task automatic expand(input int inst, input logic [255:0] kk);
    int nk, nw;
    logic [31:0] w [60];
    logic [31:0] t;
    logic [7:0] rc;
    nk = 4 + 2 * inst;
    nw = 4 * (nk + 7);
    rc = 8'h01;
    for (int i = 0; i < nk; i++) w[i] = kk[255-32*i -: 32];
    for (int i = nk; i < nw; i++) begin
      t = w[i-1];
      if (i % nk == 0) begin
        t = subw({t[23:0], t[31:24]}) ^ {rc, 24'h000000};
        rc = gmul(rc, 8'h02);
      end else if (nk == 8 && i % nk == 4) begin
        t = subw(t);
      end
      w[i] = w[i-nk] ^ t;
    end
    for (int k = 0; k < nw / 4; k++) exp_rk[inst][k] = {w[4*k], w[4*k+1], w[4*k+2], w[4*k+3]};
  endtask

  function automatic logic [255:0] key_of(input int n);
    if (n == 0) return {key0, 128'h0};
    if (n == 1) return {key1, 64'h0};
    return key2;
  endfunction

  // Compare, then advance the protocol model with the inputs the next edge will see.
  initial begin
    for (int n = 0; n < 3; n++) begin
      mode[n] = 0; gcnt[n] = 0; kidx[n] = 0; done[n] = 0; accept_cyc[n] = 0; last_cyc[n] = 0;
    end
    forever begin
      @(negedge clk);
      if (run_chk) begin
        for (int n = 0; n < 3; n++) begin
          chk($sformatf("i%0d_ctl", n), {key_ready[n], busy[n], rk_valid[n]},
              {mode[n] == 0, mode[n] != 0, mode[n] == 2});
          if (mode[n] == 2) begin
            chk($sformatf("i%0d_rk%0d_data", n, kidx[n]), rk_data[n], exp_rk[n][kidx[n]]);
            chk($sformatf("i%0d_rk_idx", n), rk_idx[n], 128'(kidx[n]));
            chk($sformatf("i%0d_rk_last", n), rk_last[n], kidx[n] == nr_of[n]);
          end
          if (rst || abort) begin
            mode[n] = 0;
            kidx[n] = 0;
          end else if (mode[n] == 0) begin
            if (key_valid[n]) begin
              mode[n] = 1; gcnt[n] = 4; kidx[n] = 0;
              expand(n, key_of(n));
              accept_cyc[n] = cyc + 1;
            end
          end else if (mode[n] == 1) begin
            gcnt[n]--;
            if (gcnt[n] == 0) begin
              mode[n] = 2;
              if (kidx[n] == nr_of[n]) last_cyc[n] = cyc + 1;
            end
          end else if (rk_ready) begin
            if (kidx[n] == nr_of[n]) begin
              mode[n] = 0;
              done[n]++;
            end else begin
              kidx[n]++;
              mode[n] = 1;
              gcnt[n] = 4;
            end
          end
        end
      end
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic wait_idle(input string nm, input int lim, input bit rnd);
    int n;
    n = 0;
    while (key_ready != 3'b111 && n < lim) begin
      if (rnd) rk_ready = ($urandom_range(0, 9) < 3);
      tick();
      n++;
    end
    rk_ready = 1'b1;
    chk({nm, "_timeout"}, 128'(n < lim), 128'h1);
  endtask

  initial begin
    int n;
    rst = 1'b1; abort = 1'b0; rk_ready = 1'b0; key_valid = 3'b000;
    key0 = 128'h2b7e151628aed2a6abf7158809cf4f3c;
    key1 = 192'h8e73b0f7da0e6452c810f32b809079e562f8ead2522c6b7b;
    key2 = 256'h603deb1015ca71be2b73aef0857d77811f352c073b6108d72d9810a30914dff4;

    build_sbox();
    chk("model_sbox_00", sb[0], 128'h63);
    chk("model_sbox_53", sb[8'h53], 128'hed);
    expand(0, {key0, 128'h0});
    chk("model128_rk1", exp_rk[0][1], 128'ha0fafe1788542cb123a339392a6c7605);
    chk("model128_rk10", exp_rk[0][10], 128'hd014f9a8c9ee2589e13f0cc8b6630ca6);
    expand(1, {key1, 64'h0});
    chk("model192_rk1", exp_rk[1][1], 128'h62f8ead2522c6b7bfe0c91f72402f5a5);
    chk("model192_rk12", 128'(exp_rk[1][12][31:0]), 128'h01002202);
    expand(2, key2);
    chk("model256_rk2", exp_rk[2][2], 128'h9ba354118e6925afa51a8b5f2067fcde);
    chk("model256_rk14", 128'(exp_rk[2][14][31:0]), 128'h706c631e);

    tick(); tick();
    for (int k = 0; k < 3; k++) begin
      chk($sformatf("rst_i%0d_flags", k), {key_ready[k], rk_valid[k], rk_last[k], busy[k]}, 128'b1000);
      chk($sformatf("rst_i%0d_data", k), rk_data[k], 128'h0);
      chk($sformatf("rst_i%0d_idx", k), rk_idx[k], 128'h0);
    end
    run_chk = 1'b1;
    rst = 1'b0;
    tick();

    // All three key sizes, consumer always ready.
    rk_ready = 1'b1;
    key_valid = 3'b111;
    tick();
    key_valid = 3'b000;
    wait_idle("full_rate", 200, 1'b0);
    chk("lat128", 128'(last_cyc[0] - accept_cyc[0]), 128'd54);
    chk("lat192", 128'(last_cyc[1] - accept_cyc[1]), 128'd64);
    chk("lat256", 128'(last_cyc[2] - accept_cyc[2]), 128'd74);
    for (int k = 0; k < 3; k++) chk($sformatf("done1_i%0d", k), 128'(done[k]), 128'd1);

    // Random backpressure, about 30% ready.
    key_valid = 3'b111;
    tick();
    key_valid = 3'b000;
    wait_idle("backpressure", 3000, 1'b1);
    for (int k = 0; k < 3; k++) chk($sformatf("done2_i%0d", k), 128'(done[k]), 128'd2);

    // Abort while round key 3 is offered and accepted in the same cycle.
    key_valid = 3'b001;
    tick();
    key_valid = 3'b000;
    n = 0;
    while (!(rk_valid[0] && rk_idx[0] == 4'd3) && n < 100) begin
      tick();
      n++;
    end
    chk("abort_reach_rk3", 128'(n < 100), 128'h1);
    abort = 1'b1;
    tick();
    abort = 1'b0;
    chk("abort_rk_valid", rk_valid[0], 128'h0);
    chk("abort_key_ready", key_ready[0], 128'h1);
    chk("abort_done", 128'(done[0]), 128'd2);
    key0 = 128'h000102030405060708090a0b0c0d0e0f;
    key_valid = 3'b001;
    tick();
    key_valid = 3'b000;
    wait_idle("after_abort", 200, 1'b0);
    chk("done3_i0", 128'(done[0]), 128'd3);

    // Key offered while busy, then reset mid-generation.
    key_valid = 3'b001;
    tick();
    key_valid = 3'b000;
    repeat (6) tick();
    key0 = 128'hffeeddccbbaa99887766554433221100;
    key_valid = 3'b001;
    repeat (3) begin
      tick();
      chk("busy_key_ready", key_ready[0], 128'h0);
    end
    key_valid = 3'b000;
    rst = 1'b1;
    tick();
    rst = 1'b0;
    chk("mid_rst_flags", {key_ready[0], rk_valid[0], rk_last[0], busy[0]}, 128'b1000);
    chk("mid_rst_data", rk_data[0], 128'h0);
    chk("mid_rst_idx", rk_idx[0], 128'h0);
    repeat (3) tick();
    chk("done4_i0", 128'(done[0]), 128'd3);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
